// File: rtl/mem_pkg.sv
// Shared definitions for the 16x32 dual-port memory and its burst read sequencer.
package mem_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Small synchronous FIFO holding returned read words plus their last tag.
// The head entry is presented directly from storage; push and pop may coincide.
module rd_skid_fifo #(
    parameter  int W  = 33,
    parameter  int D  = 4,
    localparam int CW = $clog2(D) + 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Push,
    input  logic [W-1:0]  Push_data,
    input  logic          Pop,
    output logic [W-1:0]  Pop_data,
    output logic [CW-1:0] Count,
    output logic          Full,
    output logic          Empty
);

    localparam int PW = $clog2(D);

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    assign Full     = (Count == CW'(D));
    assign Empty    = (Count == '0);
    assign do_pop   = Pop && !Empty;
    assign do_push  = Push && (!Full || do_pop);
    assign Pop_data = mem_q[rd_ptr_q];

    // Storage is cleared on reset so the stream outputs read as zero afterwards.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < D; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            Count    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= Push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            Count <= Count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read sequencer: issues wrapping reads into the memory, absorbs its
// one-cycle read latency and streams the words out on a valid/ready port.
//
// Handshake: a stream word transfers on every rising edge where Out_valid and
// Out_ready are both high; Out_valid/Out_data/Out_last hold while valid && !ready.
module mem_burst_reader
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int FIFO_D = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Start_addr,
    input  logic [ADDR_W:0]   Burst_len,
    output logic              Busy,
    output logic              Done,
    output logic              Rd_en,
    output logic [ADDR_W-1:0] Rd_addr,
    input  logic [DATA_W-1:0] Mem_data,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [DATA_W-1:0] Out_data,
    output logic              Out_last,
    output rd_state_t         Dbg_state
);

    localparam int CW = $clog2(FIFO_D) + 1;
    localparam int LW = ADDR_W + 1;

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LW-1:0]     remaining_q;
    logic [CW-1:0]     pending_q;
    logic              rd_last_q;
    logic              cap_en_q;
    logic              cap_last_q;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;
    logic              pop;

    logic              issue;
    logic              issue_last;
    logic [ADDR_W-1:0] issue_addr;
    logic              load;
    logic              done_d;
    logic              accept;
    logic              room;
    logic [CW:0]       occupancy;

    assign Out_valid             = !fifo_empty;
    assign {Out_last, Out_data}  = fifo_head;
    assign pop                   = Out_valid && Out_ready;
    assign accept                = (state_q == ST_IDLE) && Start;
    assign Dbg_state             = state_q;

    // Reads in flight count against buffer space so a capture always finds room.
    assign occupancy = {1'b0, fifo_count} + {1'b0, pending_q};
    assign room      = !fifo_full && (occupancy < (CW + 1)'(FIFO_D));

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_addr = addr_q;
        load       = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Burst_len != '0) begin
                        load       = 1'b1;
                        issue      = 1'b1;
                        issue_addr = Start_addr;
                        issue_last = (Burst_len == LW'(1));
                        state_d    = ST_READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (remaining_q != '0 && room) begin
                    issue      = 1'b1;
                    issue_last = (remaining_q == LW'(1));
                end
                if (remaining_q == '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish in the cycle the last word leaves the buffer.
                if (pending_q == '0 && (fifo_empty || (fifo_count == CW'(1) && pop))) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            pending_q   <= '0;
            Rd_en       <= 1'b0;
            Rd_addr     <= '0;
            rd_last_q   <= 1'b0;
            cap_en_q    <= 1'b0;
            cap_last_q  <= 1'b0;
            Done        <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            if (load) begin
                addr_q      <= Start_addr + ADDR_W'(1);
                remaining_q <= Burst_len - LW'(1);
            end else if (issue) begin
                addr_q      <= addr_q + ADDR_W'(1);
                remaining_q <= remaining_q - LW'(1);
            end
            Rd_en     <= issue;
            rd_last_q <= issue_last;
            if (issue) begin
                Rd_addr <= issue_addr;
            end
            // Memory data is valid the cycle after Rd_en; only those cycles capture.
            cap_en_q   <= Rd_en;
            cap_last_q <= rd_last_q;
            pending_q  <= pending_q + CW'(issue) - CW'(cap_en_q);
            Done       <= done_d;
            if (accept) begin
                Busy <= 1'b1;
            end else if (Done) begin
                Busy <= 1'b0;
            end
        end
    end

    rd_skid_fifo #(
        .W (DATA_W + 1),
        .D (FIFO_D)
    ) u_fifo (
        .Clk       (Clk),
        .Rst       (Rst),
        .Push      (cap_en_q),
        .Push_data ({cap_last_q, Mem_data}),
        .Pop       (pop),
        .Pop_data  (fifo_head),
        .Count     (fifo_count),
        .Full      (fifo_full),
        .Empty     (fifo_empty)
    );

endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: table of bursts checked against a queue-based
// model of the memory contents, plus reset and restart corner sequences.
module tb_mem_burst_reader;
    import mem_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int FIFO_D = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W:0]   len;
        int                mode;
        int                poke;
        int                exp_done;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   burst_len;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] mem_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    rd_state_t         dbg_state;

    logic [DATA_W-1:0] mem_arr [16];
    logic [DATA_W:0]   exp_q[$];
    vec_t              vecs [12];
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    // Registered-read memory; returns noise on cycles without a read.
    always @(posedge clk) begin
        mem_data <= rd_en ? mem_arr[rd_addr] : $urandom();
    end

    mem_burst_reader dut (
        .Clk        (clk),
        .Rst        (rst),
        .Start      (start),
        .Start_addr (start_addr),
        .Burst_len  (burst_len),
        .Busy       (busy),
        .Done       (done),
        .Rd_en      (rd_en),
        .Rd_addr    (rd_addr),
        .Mem_data   (mem_data),
        .Out_valid  (out_valid),
        .Out_ready  (out_ready),
        .Out_data   (out_data),
        .Out_last   (out_last),
        .Dbg_state  (dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ready_of(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc / 2) % 2) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_burst(input int row, input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n,
                             input int mode, input int poke, input int exp_done);
        logic [DATA_W:0]   word;
        logic [DATA_W:0]   prev_word;
        logic [DATA_W:0]   e;
        logic [ADDR_W-1:0] ea;
        logic              prev_valid;
        logic              prev_ready;
        logic [ADDR_W-1:0] addr_exp_q[$];
        int cyc, done_cyc, rd_total, hs_total, hs_lag, hs_prev, words;

        exp_q.delete();
        for (int i = 0; i < int'(n); i++) begin
            ea = a + ADDR_W'(i);
            exp_q.push_back({(i == int'(n) - 1), mem_arr[ea]});
            addr_exp_q.push_back(ea);
        end
        cyc = 0; done_cyc = -1; rd_total = 0; hs_total = 0; hs_lag = 0; words = 0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_word = '0;

        @(posedge clk); #1;
        start = 1'b1; start_addr = a; burst_len = n; out_ready = ready_of(mode, 0);
        forever begin
            @(negedge clk);
            hs_prev = hs_total;
            if (cyc == 0) check($sformatf("row%0d busy_c0", row), busy, 0);
            else if (n != 0) check($sformatf("row%0d busy", row), busy, 1);
            if (rd_en) begin
                rd_total++;
                if (rd_total == 1) check($sformatf("row%0d first_rd_cyc", row), cyc, 1);
                if (addr_exp_q.size() == 0) check($sformatf("row%0d extra_rd", row), rd_total, n);
                else begin
                    ea = addr_exp_q.pop_front();
                    check($sformatf("row%0d rd_addr", row), rd_addr, ea);
                end
                check($sformatf("row%0d rd_window", row), (rd_total - hs_lag) <= FIFO_D, 1);
            end
            word = {out_last, out_data};
            if (prev_valid && !prev_ready) begin
                check($sformatf("row%0d hold_valid", row), out_valid, 1);
                check($sformatf("row%0d hold_word", row), word, prev_word);
            end
            if (out_valid && out_ready) begin
                words++;
                hs_total++;
                if (words == 1 && mode == 0) check($sformatf("row%0d first_out_cyc", row), cyc, 3);
                if (exp_q.size() == 0) check($sformatf("row%0d extra_word", row), words, n);
                else begin
                    e = exp_q.pop_front();
                    check($sformatf("row%0d word", row), word, e);
                end
            end
            hs_lag = hs_prev;
            prev_valid = out_valid; prev_ready = out_ready; prev_word = word;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc >= 300) break;
            @(posedge clk); #1;
            cyc++;
            start = (cyc == poke);
            if (cyc == poke) begin
                start_addr = a ^ 4'h7;
                burst_len  = 5'd3;
            end
            out_ready = ready_of(mode, cyc);
        end
        start = 1'b0;
        check($sformatf("row%0d done_seen", row), done_cyc >= 0, 1);
        if (exp_done >= 0) check($sformatf("row%0d done_cyc", row), done_cyc, exp_done);
        if (n != 0) check($sformatf("row%0d busy_at_done", row), busy, 1);
        check($sformatf("row%0d words", row), words, n);
        check($sformatf("row%0d reads", row), rd_total, n);
        check($sformatf("row%0d leftover", row), exp_q.size(), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("row%0d busy_after", row), busy, 0);
        check($sformatf("row%0d valid_after", row), out_valid, 0);
    endtask

    function automatic int exp_done_of(input logic [ADDR_W:0] len, input int mode);
        if (len == 0) return 1;
        if (mode == 0) return int'(len) + 3;
        return -1;
    endfunction

    initial begin
        vecs[0] = '{4'd2,  5'd4,  0, -1, 0};
        vecs[1] = '{4'd14, 5'd4,  0, -1, 0};
        vecs[2] = '{4'd0,  5'd16, 0, -1, 0};
        vecs[3] = '{4'd5,  5'd16, 1, -1, 0};
        vecs[4] = '{4'd0,  5'd0,  0, -1, 0};
        vecs[5] = '{4'd9,  5'd0,  1, -1, 0};
        vecs[6] = '{4'd15, 5'd1,  0, -1, 0};
        vecs[7] = '{4'd3,  5'd8,  0,  4, 0};
        for (int i = 8; i < 12; i++) begin
            vecs[i].addr = 4'($urandom_range(0, 15));
            vecs[i].len  = 5'($urandom_range(1, 16));
            vecs[i].mode = $urandom_range(0, 2);
            vecs[i].poke = -1;
        end
        for (int i = 0; i < 12; i++) vecs[i].exp_done = exp_done_of(vecs[i].len, vecs[i].mode);

        for (int i = 0; i < 16; i++) mem_arr[i] = 32'hA000_0000 + 32'(i);
        rst = 1'b1; start = 1'b0; start_addr = '0; burst_len = '0; out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset rd_en", rd_en, 0);
        check("reset rd_addr", rd_addr, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_last", out_last, 0);
        check("reset state", dbg_state, ST_IDLE);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (i >= 8) begin
                for (int k = 0; k < 16; k++) mem_arr[k] = $urandom();
            end
            run_burst(i, vecs[i].addr, vecs[i].len, vecs[i].mode, vecs[i].poke, vecs[i].exp_done);
        end

        // Reset in the middle of a 16-word burst, then a short burst from 0.
        @(posedge clk); #1;
        start = 1'b1; start_addr = 4'd3; burst_len = 5'd16; out_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 5) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst rd_en", rd_en, 0);
        check("midrst rd_addr", rd_addr, 0);
        check("midrst out_valid", out_valid, 0);
        check("midrst out_data", out_data, 0);
        check("midrst out_last", out_last, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("postrst out_valid", out_valid, 0);
            check("postrst rd_en", rd_en, 0);
        end
        run_burst(12, 4'd0, 5'd2, 0, -1, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
